// File: rtl/pmbist_scan_ctrl_if.sv
// Host-side transaction bundle for pmbist_scan_ctrl: request fields, status and
// the parallel result word. The chain-side serial pins stay plain ports on the controller.
interface pmbist_scan_ctrl_if #(
    parameter int MAX_LEN = 512,
    parameter int LEN_W   = 10,
    parameter int RUN_W   = 16
);
    logic               start;
    logic               cap;
    logic [LEN_W-1:0]   len;
    logic [RUN_W-1:0]   run_cycles;
    logic [MAX_LEN-1:0] din;
    logic [MAX_LEN-1:0] exp;
    logic [MAX_LEN-1:0] mask;
    logic               busy;
    logic               done;
    logic [MAX_LEN-1:0] dout;
    logic               mismatch;

    modport master (
        output start, cap, len, run_cycles, din, exp, mask,
        input  busy, done, dout, mismatch
    );

    modport slave (
        input  start, cap, len, run_cycles, din, exp, mask,
        output busy, done, dout, mismatch
    );
endinterface

// File: rtl/pmbist_scan_ctrl.sv
// Sequencer for the pmbist serial chain: capture, shift, update, then a free-run window.
// Define PMBIST_SCAN_CMP_EN to build the masked shift-out compare that drives mismatch.
module pmbist_scan_ctrl #(
    parameter int MAX_LEN = 512,
    parameter int LEN_W   = 10,
    parameter int RUN_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    pmbist_scan_ctrl_if.slave  bus,
    output logic               select,
    output logic               capture_en,
    output logic               shift_en,
    output logic               update_en,
    output logic               si,
    input  logic               so
);
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_SHIFT,
        ST_UPDATE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [LEN_W-1:0]   len_clamp_s;
    logic [LEN_W-1:0]   len_r;
    logic [LEN_W-1:0]   cnt_r;
    logic [IDX_W-1:0]   cnt_idx_s;
    logic [RUN_W-1:0]   run_r;
    logic [MAX_LEN-1:0] din_sh_r;
    logic [MAX_LEN-1:0] dout_r;
    logic               si_nxt_s;
    logic               select_r;
    logic               capture_en_r;
    logic               shift_en_r;
    logic               update_en_r;
    logic               si_r;
    logic               busy_r;
    logic               done_r;

    assign len_clamp_s = (bus.len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.len;
    assign cnt_idx_s   = cnt_r[IDX_W-1:0];

    // Next-state decode and the serial bit to present in the upcoming cycle.
    always_comb begin
        state_nxt_s = state_r;
        si_nxt_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.cap) begin
                        state_nxt_s = ST_CAPTURE;
                    end else if (len_clamp_s == LEN_W'(0)) begin
                        state_nxt_s = ST_UPDATE;
                    end else begin
                        state_nxt_s = ST_SHIFT;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                if (len_r == LEN_W'(0)) begin
                    state_nxt_s = ST_UPDATE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == len_r - LEN_W'(1)) begin
                    state_nxt_s = ST_UPDATE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_UPDATE: begin
                if (run_r != RUN_W'(0)) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            ST_RUN: begin
                if (run_r == RUN_W'(1)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        // din_sh_r[0] always holds the next bit still to be driven; din is not latched yet in IDLE.
        if (state_nxt_s == ST_SHIFT) begin
            if (state_r == ST_IDLE) begin
                si_nxt_s = bus.din[0];
            end else begin
                si_nxt_s = din_sh_r[0];
            end
        end else begin
            si_nxt_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            select_r     <= 1'b0;
            capture_en_r <= 1'b0;
            shift_en_r   <= 1'b0;
            update_en_r  <= 1'b0;
            si_r         <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            select_r     <= (state_nxt_s == ST_CAPTURE) || (state_nxt_s == ST_SHIFT) ||
                            (state_nxt_s == ST_UPDATE);
            capture_en_r <= (state_nxt_s == ST_CAPTURE);
            shift_en_r   <= (state_nxt_s == ST_SHIFT);
            update_en_r  <= (state_nxt_s == ST_UPDATE);
            si_r         <= si_nxt_s;
            busy_r       <= (state_nxt_s != ST_IDLE);
            done_r       <= (state_nxt_s == ST_DONE);
        end
    end

    // Request latch, shift datapath, result collection and run countdown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_r    <= '0;
            cnt_r    <= '0;
            run_r    <= '0;
            din_sh_r <= '0;
            dout_r   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        len_r  <= len_clamp_s;
                        cnt_r  <= '0;
                        run_r  <= bus.run_cycles;
                        dout_r <= '0;
                        if (state_nxt_s == ST_SHIFT) begin
                            din_sh_r <= bus.din >> 1'b1;
                        end else begin
                            din_sh_r <= bus.din;
                        end
                    end
                end
                ST_CAPTURE: begin
                    din_sh_r <= din_sh_r >> 1'b1;
                end
                ST_SHIFT: begin
                    dout_r[cnt_idx_s] <= so;
                    din_sh_r          <= din_sh_r >> 1'b1;
                    cnt_r             <= cnt_r + LEN_W'(1);
                end
                ST_RUN: begin
                    run_r <= run_r - RUN_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

`ifdef PMBIST_SCAN_CMP_EN
    logic [MAX_LEN-1:0] exp_sh_r;
    logic [MAX_LEN-1:0] mask_sh_r;
    logic               mismatch_r;

    // Accumulate the masked compare one bit at a time as each so bit is captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_sh_r   <= '0;
            mask_sh_r  <= '0;
            mismatch_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        exp_sh_r   <= bus.exp;
                        mask_sh_r  <= bus.mask;
                        mismatch_r <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    mismatch_r <= mismatch_r | ((so ^ exp_sh_r[0]) & mask_sh_r[0]);
                    exp_sh_r   <= exp_sh_r >> 1'b1;
                    mask_sh_r  <= mask_sh_r >> 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.mismatch = mismatch_r;
`else
    logic unused_cmp_s;

    assign unused_cmp_s = ^{bus.exp, bus.mask};
    assign bus.mismatch = 1'b0;
`endif

    assign select     = select_r;
    assign capture_en = capture_en_r;
    assign shift_en   = shift_en_r;
    assign update_en  = update_en_r;
    assign si         = si_r;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.dout   = dout_r;
endmodule
